// File: rtl/tile_acc_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_acc_drain_if
// Description : Tile capture and row-drain bundle between the systolic array,
//               the accumulator and the write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_acc_drain_if;
    logic                     i_valid;
    logic [0:3][0:3][15:0]    i_tile;
    logic                     o_busy;
    logic                     o_row_valid;
    logic                     o_row_ready;
    logic [0:3][15:0]         o_row_data;
    logic [1:0]               o_row_idx;
    logic                     o_tile_done;
    logic                     o_drop;

    modport master (
        output i_valid, i_tile, o_row_ready,
        input  o_busy, o_row_valid, o_row_data, o_row_idx, o_tile_done, o_drop
    );

    modport slave (
        input  i_valid, i_tile, o_row_ready,
        output o_busy, o_row_valid, o_row_data, o_row_idx, o_tile_done, o_drop
    );
endinterface
`default_nettype wire

// File: rtl/tile_acc_drain.sv
`default_nettype none
// ============================================================================
// Module      : tile_acc_drain
// Description : Accumulates K_TILES partial 4x4 Q1.15 tiles with saturation
//               and drains the result one row per valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_acc_drain #(
    parameter int K_TILES = 2,
    parameter int DATA_W  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    tile_acc_drain_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [0:3][0:3][DATA_W-1:0]     acc_q, acc_d;
    logic [3:0]                      k_q, k_d;
    logic [1:0]                      row_idx_q, row_idx_d;
    logic                            tile_done_q, tile_done_d;
    logic                            drop_q, drop_d;

    logic                            w_hs;
    logic                            w_last_hs;
    logic                            w_capture;

    // Two's-complement add clamped to the Q1.15 range.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W:DATA_W-1] == 2'b01)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (s[DATA_W:DATA_W-1] == 2'b10)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return s[DATA_W-1:0];
    endfunction

    assign w_hs      = (state_q == ST_DRAIN) && bus.o_row_ready;
    assign w_last_hs = w_hs && (row_idx_q == 2'd3);
    // A tile arriving on the final handshake opens the next group instead of being dropped.
    assign w_capture = bus.i_valid && ((state_q == ST_ACCUM) || w_last_hs);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        k_d         = k_q;
        row_idx_d   = row_idx_q;
        tile_done_d = 1'b0;
        drop_d      = 1'b0;

        if (state_q == ST_DRAIN) begin
            if (w_hs)
                row_idx_d = row_idx_q + 2'd1;
            if (w_last_hs) begin
                state_d     = ST_ACCUM;
                tile_done_d = 1'b1;
            end
            if (bus.i_valid && !w_last_hs)
                drop_d = 1'b1;
        end

        // k is always zero in DRAIN, so an overlapped capture loads directly.
        if (w_capture) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (k_q == 4'd0)
                        acc_d[r][c] = bus.i_tile[r][c];
                    else
                        acc_d[r][c] = sat_add(acc_q[r][c], bus.i_tile[r][c]);
                end
            end
            if (k_q == 4'(K_TILES - 1)) begin
                k_d     = 4'd0;
                state_d = ST_DRAIN;
            end else begin
                k_d = k_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            k_q         <= 4'd0;
            row_idx_q   <= 2'd0;
            tile_done_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            row_idx_q   <= row_idx_d;
            tile_done_q <= tile_done_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.o_busy      = (state_q == ST_DRAIN);
    assign bus.o_row_valid = (state_q == ST_DRAIN);
    assign bus.o_row_data  = acc_q[row_idx_q];
    assign bus.o_row_idx   = row_idx_q;
    assign bus.o_tile_done = tile_done_q;
    assign bus.o_drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_acc_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_acc_drain
// Description : Drives a K_TILES=2 and a K_TILES=1 instance with identical
//               stimulus and compares both against a tile-level scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_acc_drain;

    typedef logic [0:3][0:3][15:0] tile_t;
    typedef logic [0:3][15:0]      row_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    tile_acc_drain_if bus2 ();
    tile_acc_drain_if bus1 ();

    tile_acc_drain #(.K_TILES(2), .DATA_W(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    tile_acc_drain #(.K_TILES(1), .DATA_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: at most one finished tile is ever pending for drain.
    logic       pend     [2];
    tile_t      exp_tile [2];
    tile_t      grp      [2];
    logic [1:0] row      [2];
    int         cnt      [2];
    logic       edone    [2];
    logic       edrop    [2];

    function automatic logic [15:0] sat(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)       return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else                 return s[15:0];
    endfunction

    function automatic tile_t fill(input logic [15:0] v);
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = v;
        return t;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                case ($urandom % 4)
                    0:       t[r][c] = 16'h6000 + 16'($urandom % 16'h2000);
                    1:       t[r][c] = 16'h8000 + 16'($urandom % 16'h2000);
                    default: t[r][c] = 16'($urandom);
                endcase
        return t;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int i);
        logic busy, rv, done, drop;
        logic [1:0] idx;
        row_t d;
        if (i == 0) begin
            busy = bus2.o_busy; rv = bus2.o_row_valid; done = bus2.o_tile_done;
            drop = bus2.o_drop; idx = bus2.o_row_idx; d = bus2.o_row_data;
        end else begin
            busy = bus1.o_busy; rv = bus1.o_row_valid; done = bus1.o_tile_done;
            drop = bus1.o_drop; idx = bus1.o_row_idx; d = bus1.o_row_data;
        end
        chk("busy", i, 64'(busy), 64'(pend[i]));
        chk("row_valid", i, 64'(rv), 64'(pend[i]));
        chk("tile_done", i, 64'(done), 64'(edone[i]));
        chk("drop", i, 64'(drop), 64'(edrop[i]));
        chk("row_idx", i, 64'(idx), 64'(row[i]));
        if (pend[i])
            chk("row_data", i, d, exp_tile[i][row[i]]);
    endtask

    task automatic model_update(input int i, input logic v, input tile_t t,
                                input logic rdy, input logic r);
        int   kk;
        logic was, hs, last;
        kk = (i == 0) ? 2 : 1;
        if (r) begin
            pend[i] = 1'b0; row[i] = 2'd0; cnt[i] = 0; edone[i] = 1'b0; edrop[i] = 1'b0;
        end else begin
            was  = pend[i];
            hs   = was && rdy;
            last = hs && (row[i] == 2'd3);
            edone[i] = last;
            edrop[i] = v && was && !last;
            if (hs)   row[i] = row[i] + 2'd1;
            if (last) pend[i] = 1'b0;
            if (v && (!was || last)) begin
                for (int rr = 0; rr < 4; rr++)
                    for (int cc = 0; cc < 4; cc++)
                        grp[i][rr][cc] = (cnt[i] == 0) ? t[rr][cc] : sat(grp[i][rr][cc], t[rr][cc]);
                cnt[i]++;
                if (cnt[i] == kk) begin
                    exp_tile[i] = grp[i];
                    pend[i]     = 1'b1;
                    row[i]      = 2'd0;
                    cnt[i]      = 0;
                end
            end
        end
    endtask

    // Called at a falling edge: check current outputs, drive inputs, advance one cycle.
    task automatic step(input logic v, input tile_t t, input logic rdy, input logic r);
        check_inst(0);
        check_inst(1);
        bus2.i_valid = v; bus2.i_tile = t; bus2.o_row_ready = rdy;
        bus1.i_valid = v; bus1.i_tile = t; bus1.o_row_ready = rdy;
        rst = r;
        model_update(0, v, t, rdy, r);
        model_update(1, v, t, rdy, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t  vecs [6];
    tile_t ta, tb;

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{16'h1000, 16'h0800, 16'h1800};
        vecs[1] = '{16'h7000, 16'h2000, 16'h7FFF};
        vecs[2] = '{16'h9000, 16'hE000, 16'h8000};
        vecs[3] = '{16'h0001, 16'hFFFF, 16'h0000};
        vecs[4] = '{16'h0100, 16'h0100, 16'h0200};
        vecs[5] = '{16'h7FFF, 16'h8000, 16'hFFFF};

        rst = 1'b1;
        bus2.i_valid = 1'b0; bus2.i_tile = '0; bus2.o_row_ready = 1'b0;
        bus1.i_valid = 1'b0; bus1.i_tile = '0; bus1.o_row_ready = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) model_update(i, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_busy", 0, 64'(bus2.o_busy), 64'd0);
        chk("rst_row_valid", 0, 64'(bus2.o_row_valid), 64'd0);
        chk("rst_row_idx", 0, 64'(bus2.o_row_idx), 64'd0);
        chk("rst_row_data", 0, bus2.o_row_data, 64'd0);
        chk("rst_tile_done", 0, 64'(bus2.o_tile_done), 64'd0);
        chk("rst_drop", 0, 64'(bus2.o_drop), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Uniform two-tile groups with fixed expected sums, ready held high.
        for (int v = 0; v < 6; v++) begin
            step(1'b1, fill(vecs[v].a), 1'b1, 1'b0);
            step(1'b1, fill(vecs[v].b), 1'b1, 1'b0);
            for (int r = 0; r < 4; r++) begin
                chk("tbl_row_data", 0, bus2.o_row_data, {4{vecs[v].sum}});
                chk("tbl_row_idx", 0, 64'(bus2.o_row_idx), 64'(r));
                step(1'b0, '0, 1'b1, 1'b0);
            end
            chk("tbl_done", 0, 64'(bus2.o_tile_done), 64'd1);
            chk("tbl_idle", 0, 64'(bus2.o_row_valid), 64'd0);
        end

        // Element-wise saturation in both directions plus exact cancellation.
        ta = '0; tb = '0;
        ta[0][0] = 16'h7000; tb[0][0] = 16'h2000;
        ta[1][1] = 16'h9000; tb[1][1] = 16'hE000;
        ta[2][2] = 16'h0001; tb[2][2] = 16'hFFFF;
        step(1'b1, ta, 1'b1, 1'b0);
        step(1'b1, tb, 1'b1, 1'b0);
        chk("sat_pos", 0, 64'(bus2.o_row_data[0]), 64'h7FFF);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("sat_neg", 0, 64'(bus2.o_row_data[1]), 64'h8000);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("sat_zero", 0, 64'(bus2.o_row_data[2]), 64'h0000);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure on row 1 for five cycles.
        step(1'b1, rand_tile(), 1'b1, 1'b0);
        step(1'b1, rand_tile(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            chk("bp_idx", 0, 64'(bus2.o_row_idx), 64'd1);
            chk("bp_busy", 0, 64'(bus2.o_busy), 64'd1);
            step(1'b0, '0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b1, 1'b0);

        // Tile arriving mid-drain is dropped.
        step(1'b1, fill(16'h0200), 1'b1, 1'b0);
        step(1'b1, fill(16'h0300), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, fill(16'h4444), 1'b0, 1'b0);
        chk("drop_pulse", 0, 64'(bus2.o_drop), 64'd1);
        chk("drop_data", 0, bus2.o_row_data, {4{16'h0500}});
        for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b1, 1'b0);

        // Overlap on the K=1 instance: new tile coincides with the row-3 handshake.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, fill(16'h0D0D), 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            chk("ovl_rv", 1, 64'(bus1.o_row_valid), 64'd1);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b1, fill(16'h0C0C), 1'b1, 1'b0);
        chk("ovl_done", 1, 64'(bus1.o_tile_done), 64'd1);
        chk("ovl_rv_held", 1, 64'(bus1.o_row_valid), 64'd1);
        chk("ovl_row0", 1, bus1.o_row_data, {4{16'h0C0C}});
        for (int n = 0; n < 5; n++) step(1'b0, '0, 1'b1, 1'b0);

        // Reset after the row-2 handshake abandons the drain.
        step(1'b1, fill(16'h3000), 1'b1, 1'b0);
        step(1'b1, fill(16'h3000), 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("rstmid_rv", 0, 64'(bus2.o_row_valid), 64'd0);
        chk("rstmid_busy", 0, 64'(bus2.o_busy), 64'd0);
        chk("rstmid_done", 0, 64'(bus2.o_tile_done), 64'd0);
        step(1'b1, fill(16'h0100), 1'b1, 1'b0);
        step(1'b1, fill(16'h0100), 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            chk("rstmid_row", 0, bus2.o_row_data, {4{16'h0200}});
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Randomised traffic against the scoreboard.
        for (int n = 0; n < 600; n++)
            step(($urandom % 3) == 0, rand_tile(), ($urandom % 4) != 0, ($urandom % 97) == 0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_acc_drain.md
Name: tile_acc_drain

Overview:
- Sits directly downstream of the 4x4 systolic array.
- Captures each finished 4x4 Q1.15 output tile on the array's single-cycle valid pulse.
- Accumulates K_TILES partial tiles (the K-dimension split) with signed saturating addition.
- Drains the accumulated tile one row per handshake to the write-back path, using a valid/ready interface.

Parameters:
- K_TILES, 2, number of partial tiles summed per output tile; legal range 1..15.
- DATA_W, 16, element width, signed Q1.15; only 16 is supported.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  one-cycle pulse; i_tile is valid (driven from the array's o_valid).
- i_tile  input  16 x [0:3][0:3]  tile elements; element [r][c] is row r, column c.
- o_busy  output  1  high in DRAIN; upstream holds off starting a new tile.
- o_row_valid  output  1  a row is presented on o_row_data.
- o_row_ready  input  1  downstream accepts the row when high together with o_row_valid.
- o_row_data  output  16 x [0:3]  accumulated row o_row_idx; element c is column c.
- o_row_idx  output  2  index of the row being presented, 0..3.
- o_tile_done  output  1  one-cycle pulse, the cycle after row 3 is accepted.
- o_drop  output  1  one-cycle pulse, the cycle after an i_valid was discarded.

Behaviour:
Reset:
- Synchronous: applies at the rising clk edge while rst=1, and overrides every other event.
- State goes to ACCUM; accumulator, k count and row_idx are cleared.
- Outputs after reset: o_busy=0, o_row_valid=0, o_row_idx=0, o_row_data=0, o_tile_done=0, o_drop=0.
- Reset in the middle of a drain abandons the remaining rows; no o_tile_done is generated.

State machine:
- ACCUM -> DRAIN at the edge that captures the K_TILES-th tile.
- DRAIN -> ACCUM at the edge where row 3 handshakes.

Capture in ACCUM:
- At an edge with i_valid=1 and k=0, acc[r][c] is loaded with i_tile[r][c].
- At an edge with i_valid=1 and k>0, acc[r][c] becomes sat16(acc[r][c] + i_tile[r][c]).
- Every capture increments k.
- When k reaches K_TILES, the state becomes DRAIN at that same edge and k returns to 0.

Saturation (sat16):
- The 17-bit signed sum is clamped: above 32767 gives 0x7FFF, below -32768 gives 0x8000, otherwise the sum.
- Saturation is applied after each addition (it is not deferred to the end).

Drain:
- o_row_valid=1 and o_busy=1 for the whole time the state is DRAIN.
- o_row_data = acc[o_row_idx], driven combinationally from registers.
- The first row is presented the cycle after the final capture, i.e. latency 1 cycle from the final i_valid to o_row_valid.
- A handshake (o_row_valid && o_row_ready at an edge) increments row_idx.
- While o_row_ready=0, o_row_data and o_row_idx are held stable; there are no bubbles between rows when ready stays high.
- Minimum drain time is 4 cycles.
- At the row-3 handshake: row_idx wraps to 0, the state returns to ACCUM, and o_tile_done pulses in the next cycle.
- o_row_valid drops in the cycle after the row-3 handshake, unless rst intervenes.

Simultaneous events:
- i_valid at the same edge as the row-3 handshake: the tile is accepted as capture k=0 of the next group.
  - The accumulator loads i_tile directly and k becomes 1.
  - If K_TILES=1, the state stays DRAIN, row_idx becomes 0, and the new tile drains next with no idle cycle; o_tile_done still pulses.
- i_valid in DRAIN at any other edge: the tile is discarded, o_drop pulses in the next cycle, and the accumulator is unchanged.
- i_valid in the same cycle as rst: ignored.

Other rules:
- o_row_ready while o_row_valid=0 has no effect.
- K_TILES=1 makes the block a capture-and-serialize buffer; saturation is never invoked.

Test Plan:
1. K_TILES=2, o_row_ready held 1; tile A all 0x1000, then tile B all 0x0800 -> rows 0..3 each {0x1800 x4} on 4 consecutive cycles starting 1 cycle after B. o_tile_done pulses once, 1 cycle after row 3.
2. Saturation, K_TILES=2; A[0][0]=0x7000 + B[0][0]=0x2000, and A[1][1]=0x9000 + B[1][1]=0xE000 -> element [0][0] reads 0x7FFF, element [1][1] reads 0x8000. An element with 0x0001 + 0xFFFF reads 0x0000.
3. Backpressure: o_row_ready low for 5 cycles on row 1 -> o_row_idx=1 and o_row_data held constant for 5 cycles, o_busy=1 throughout. Rows 2 and 3 then follow back to back once ready returns.
4. Drop: i_valid pulses while in DRAIN at row 1 -> o_drop=1 the next cycle; the drained values equal the pre-drop accumulation.
5. Overlap, K_TILES=1: i_valid with tile C coincides with the row-3 handshake of tile D -> o_tile_done pulses; C row 0 is presented the next cycle; o_row_valid never deasserts.
6. Reset mid-drain: rst=1 for one edge after the row-2 handshake -> next cycle o_row_valid=0, o_busy=0, no o_tile_done. A following two-tile group of 0x0100 + 0x0100 drains {0x0200 x4} on every row, with no residue from the old accumulation.
